// File: rtl/mac_pkg.sv
// Shared types and widths for the two-port MAC sequencing controller.
package mac_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 25;
  localparam int MUL1_W = 17;

  localparam logic RES_SRC_TRI = 1'b0;
  localparam logic RES_SRC_SOP = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    T_P1,
    T_W1,
    T_P2,
    T_W2,
    S_TERM,
    S_ISSUE,
    S_WAIT,
    OUT
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant, combinational from the requests; rr_last moves on every grant.
// Reset leaves rr_last at 1, so port 0 wins the first contention.
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic grant0,
  output logic grant1
);

  logic rr_last;

  assign grant0 = en & req0 & (~req1 | rr_last);
  assign grant1 = en & req1 & (~req0 | ~rr_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last <= 1'b1;
    end else if (grant0 | grant1) begin
      rr_last <= grant1;
    end
  end

endmodule

// File: rtl/mac_shared_scheduler.sv
// Shares one external MAC between trinomial jobs (port 0) and sum-of-products streams (port 1).
// Trinomial result 2L+3 cycles after accept; one MAC op in flight; result held until res_ready.
module mac_shared_scheduler #(
  parameter int DATA_W  = mac_pkg::DATA_W,
  parameter int ACC_W   = mac_pkg::ACC_W,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                t_valid,
  output logic                t_ready,
  input  logic [DATA_W-1:0]   t_a,
  input  logic [DATA_W-1:0]   t_b,
  input  logic [DATA_W-1:0]   t_c,
  input  logic [DATA_W-1:0]   t_x,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_a,
  input  logic [DATA_W-1:0]   s_x,
  input  logic                s_last,
  output logic                mac_op_valid,
  output logic [16:0]         mac_mul_1,
  output logic [DATA_W-1:0]   mac_mul_2,
  output logic [ACC_W-1:0]    mac_add,
  input  logic                mac_res_valid,
  input  logic [ACC_W-1:0]    mac_res,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [ACC_W-1:0]    res_data,
  output logic                res_src,
  output logic                res_err
);

  import mac_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t state, next_state;

  logic              grant0, grant1;
  logic [DATA_W-1:0] a_q, b_q, c_q, x_q;
  logic              last_q;
  logic [16:0]       p1_q;
  logic [ACC_W-1:0]  acc_q, res_q;
  logic              src_q, err_q;
  logic [CNT_W-1:0]  idle_cnt;
  logic              timeout_hit;

  logic [16:0]       a_ext17;
  logic [ACC_W-1:0]  b_ext, c_ext;

  assign a_ext17 = {{(17 - DATA_W){a_q[DATA_W-1]}}, a_q};
  assign b_ext   = {{(ACC_W - DATA_W){b_q[DATA_W-1]}}, b_q};
  assign c_ext   = {{(ACC_W - DATA_W){c_q[DATA_W-1]}}, c_q};

  assign timeout_hit = (state == S_TERM) && !s_valid && (idle_cnt == CNT_W'(TIMEOUT - 1));

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .en     (state == IDLE),
    .req0   (t_valid),
    .req1   (s_valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant0) begin
          next_state = T_P1;
        end else if (grant1) begin
          next_state = S_ISSUE;
        end
      end
      T_P1:    next_state = T_W1;
      T_W1:    if (mac_res_valid) next_state = T_P2;
      T_P2:    next_state = T_W2;
      T_W2:    if (mac_res_valid) next_state = OUT;
      S_ISSUE: next_state = S_WAIT;
      S_WAIT: begin
        if (mac_res_valid) begin
          next_state = last_q ? OUT : S_TERM;
        end
      end
      S_TERM: begin
        if (s_valid) begin
          next_state = S_ISSUE;
        end else if (timeout_hit) begin
          next_state = OUT;
        end
      end
      OUT:     if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    t_ready      = 1'b0;
    s_ready      = 1'b0;
    mac_op_valid = 1'b0;
    mac_mul_1    = '0;
    mac_mul_2    = '0;
    mac_add      = '0;
    res_valid    = 1'b0;
    res_data     = '0;
    res_src      = 1'b0;
    res_err      = 1'b0;
    case (state)
      IDLE: begin
        t_ready = grant0;
        s_ready = grant1;
      end
      T_P1: begin
        mac_op_valid = 1'b1;
        mac_mul_1    = a_ext17;
        mac_mul_2    = x_q;
        mac_add      = b_ext;
      end
      T_P2: begin
        mac_op_valid = 1'b1;
        mac_mul_1    = p1_q;
        mac_mul_2    = x_q;
        mac_add      = c_ext;
      end
      S_ISSUE: begin
        mac_op_valid = 1'b1;
        mac_mul_1    = a_ext17;
        mac_mul_2    = x_q;
        mac_add      = acc_q;
      end
      S_TERM: s_ready = 1'b1;
      OUT: begin
        res_valid = 1'b1;
        res_data  = res_q;
        res_src   = src_q;
        res_err   = err_q;
      end
      default: ;
    endcase
  end

  // Operand, accumulator and result registers; MAC results outside the wait states are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      x_q      <= '0;
      last_q   <= 1'b0;
      p1_q     <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      src_q    <= 1'b0;
      err_q    <= 1'b0;
      idle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0) begin
            a_q <= t_a;
            b_q <= t_b;
            c_q <= t_c;
            x_q <= t_x;
          end else if (grant1) begin
            a_q    <= s_a;
            x_q    <= s_x;
            last_q <= s_last;
          end
        end
        T_W1: begin
          if (mac_res_valid) begin
            p1_q <= mac_res[16:0];
          end
        end
        T_W2: begin
          if (mac_res_valid) begin
            res_q <= mac_res;
            src_q <= RES_SRC_TRI;
            err_q <= 1'b0;
          end
        end
        S_WAIT: begin
          idle_cnt <= '0;
          if (mac_res_valid) begin
            acc_q <= mac_res;
            if (last_q) begin
              res_q <= mac_res;
              src_q <= RES_SRC_SOP;
              err_q <= 1'b0;
            end
          end
        end
        S_TERM: begin
          if (s_valid) begin
            a_q      <= s_a;
            x_q      <= s_x;
            last_q   <= s_last;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
            if (timeout_hit) begin
              res_q <= acc_q;
              src_q <= RES_SRC_SOP;
              err_q <= 1'b1;
            end
          end
        end
        OUT: begin
          if (res_ready && src_q == RES_SRC_SOP) begin
            acc_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_shared_scheduler.sv
// Directed bench for mac_shared_scheduler with a behavioural MAC of selectable latency.
module tb_mac_shared_scheduler;

  localparam int AW = 25;

  logic clk = 1'b0;
  logic reset;
  logic t_valid, t_ready;
  logic signed [7:0] t_a, t_b, t_c, t_x;
  logic s_valid, s_ready, s_last;
  logic signed [7:0] s_a, s_x;
  logic mac_op_valid;
  logic signed [16:0] mac_mul_1;
  logic signed [7:0] mac_mul_2;
  logic signed [24:0] mac_add;
  logic mac_res_valid;
  logic signed [24:0] mac_res;
  logic res_valid, res_ready, res_src, res_err;
  logic signed [24:0] res_data;

  int errors = 0;
  int checks = 0;
  int mac_lat = 1;
  int leak = 0;
  logic mon_en = 1'b0;

  logic vpipe [8];
  logic signed [24:0] rpipe [8];

  always #5 clk = ~clk;

  mac_shared_scheduler dut (
    .clk(clk), .reset(reset),
    .t_valid(t_valid), .t_ready(t_ready), .t_a(t_a), .t_b(t_b), .t_c(t_c), .t_x(t_x),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_x(s_x), .s_last(s_last),
    .mac_op_valid(mac_op_valid), .mac_mul_1(mac_mul_1), .mac_mul_2(mac_mul_2), .mac_add(mac_add),
    .mac_res_valid(mac_res_valid), .mac_res(mac_res),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_src(res_src), .res_err(res_err)
  );

  // Behavioural MAC: not reset, so an in-flight result still emerges after a scheduler reset.
  initial begin
    for (int i = 0; i < 8; i++) begin
      vpipe[i] = 1'b0;
      rpipe[i] = '0;
    end
  end

  always @(posedge clk) begin
    vpipe[0] <= mac_op_valid;
    rpipe[0] <= AW'(longint'(mac_mul_1) * longint'(mac_mul_2) + longint'(mac_add));
    for (int i = 1; i < 8; i++) begin
      vpipe[i] <= vpipe[i-1];
      rpipe[i] <= rpipe[i-1];
    end
  end

  assign mac_res_valid = vpipe[mac_lat-1];
  assign mac_res       = rpipe[mac_lat-1];

  always @(negedge clk) begin
    if (mon_en && t_ready) leak++;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic tri_accept(input int a, input int b, input int c, input int x);
    int n;
    n = 0;
    t_a = 8'(a); t_b = 8'(b); t_c = 8'(c); t_x = 8'(x);
    t_valid = 1'b1;
    #1;
    while (!t_ready && n < 50) begin
      tick;
      n++;
    end
    if (!t_ready) check("tri_accept_wait", 0, 1);
    tick;
    t_valid = 1'b0;
  endtask

  task automatic sop_accept(input int a, input int x, input logic last);
    int n;
    n = 0;
    s_a = 8'(a); s_x = 8'(x); s_last = last;
    s_valid = 1'b1;
    #1;
    while (!s_ready && n < 50) begin
      tick;
      n++;
    end
    if (!s_ready) check("sop_accept_wait", 0, 1);
    tick;
    s_valid = 1'b0;
  endtask

  // Called right after an accept edge: cycle 1 is the cycle following that edge.
  task automatic wait_res(input int maxc, output int cyc);
    cyc = 1;
    while (!res_valid && cyc < maxc) begin
      tick;
      cyc++;
    end
    if (!res_valid) check("res_wait", 0, 1);
  endtask

  task automatic take_res(input string tag, input longint d, input longint src, input longint err);
    check({tag, "_data"}, res_data, d);
    check({tag, "_src"}, res_src, src);
    check({tag, "_err"}, res_err, err);
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    check({tag, "_released"}, res_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int bad;
    int sa [3] = '{2, -4, 7};
    int sx [3] = '{3, 5, 7};

    reset = 1'b1;
    t_valid = 0; t_a = 0; t_b = 0; t_c = 0; t_x = 0;
    s_valid = 0; s_a = 0; s_x = 0; s_last = 0;
    res_ready = 0;
    #12;
    check("rst_res_valid", res_valid, 0);
    check("rst_mac_op", mac_op_valid, 0);
    check("rst_t_ready", t_ready, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_res_data", res_data, 0);
    @(negedge clk);
    reset = 1'b0;
    tick;

    // Trinomial L=1: (-5*-3-2)*-3-1 = -40, first seen in cycle 5
    mac_lat = 1;
    tri_accept(-5, -2, -1, -3);
    wait_res(20, cyc);
    check("t1_latency", cyc, 5);
    take_res("t1", -40, 0, 0);

    // Trinomial 9,8,7,6 = 638 held under backpressure
    tri_accept(9, 7, 6, 8);
    wait_res(20, cyc);
    repeat (4) begin
      check("t2_hold_valid", res_valid, 1);
      check("t2_hold_data", res_data, 638);
      tick;
    end
    take_res("t2", 638, 0, 0);

    // SOP 2*3 - 4*5 + 7*7 = 35 with a trinomial job pending throughout
    mac_lat = 2;
    t_a = 1; t_b = 1; t_c = 1; t_x = 1;
    t_valid = 1'b1;
    mon_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sop_accept(sa[k], sx[k], k == 2);
      if (k < 2) begin
        cyc = 1;
        while (!s_ready && cyc < 20) begin
          tick;
          cyc++;
        end
        check("t3_term_latency", cyc, mac_lat + 2);
      end
    end
    wait_res(20, cyc);
    mon_en = 1'b0;
    check("t3_t_stalled", leak, 0);
    take_res("t3", 35, 1, 0);
    check("t3_t_ready_after", t_ready, 1);
    tri_accept(1, 1, 1, 1);
    wait_res(20, cyc);
    take_res("t3tri", 3, 0, 0);

    // Alternation after reset with both ports requesting
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    mac_lat = 1;
    t_a = 1; t_b = 0; t_c = 0; t_x = 2;
    s_a = 2; s_x = -3; s_last = 1'b1;
    t_valid = 1'b1;
    s_valid = 1'b1;
    #1;
    check("t4_first_t", t_ready, 1);
    check("t4_first_s", s_ready, 0);
    tick;
    wait_res(20, cyc);
    take_res("t4a", 4, 0, 0);
    check("t4_second_t", t_ready, 0);
    check("t4_second_s", s_ready, 1);
    tick;
    wait_res(20, cyc);
    take_res("t4b", -6, 1, 0);
    check("t4_third_t", t_ready, 1);
    check("t4_third_s", s_ready, 0);
    tick;
    t_valid = 1'b0;
    s_valid = 1'b0;
    wait_res(20, cyc);
    take_res("t4c", 4, 0, 0);

    // SOP timeout after 16 idle S_TERM cycles, then a fresh job from acc=0
    sop_accept(3, 4, 1'b0);
    wait_res(60, cyc);
    check("t5_timeout_latency", cyc, mac_lat + 2 + 16);
    take_res("t5", 12, 1, 1);
    sop_accept(5, 5, 1'b1);
    wait_res(20, cyc);
    take_res("t5b", 25, 1, 0);

    // Reset during T_W1 with the MAC result landing afterwards
    mac_lat = 4;
    tri_accept(2, 1, -7, 3);
    tick;
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_res_valid", res_valid, 0);
    check("t6_rst_mac_op", mac_op_valid, 0);
    check("t6_rst_mul_1", mac_mul_1, 0);
    check("t6_rst_add", mac_add, 0);
    check("t6_rst_res_data", res_data, 0);
    check("t6_rst_s_ready", s_ready, 0);
    tick;
    reset = 1'b0;
    bad = 0;
    repeat (8) begin
      if (res_valid || mac_op_valid) bad++;
      tick;
    end
    check("t6_quiet", bad, 0);
    tri_accept(2, 1, -7, 3);
    wait_res(40, cyc);
    check("t6_latency", cyc, 2 * mac_lat + 3);
    take_res("t6", 14, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_shared_scheduler.md
Name: mac_shared_scheduler

Overview:
Sequencing controller that shares one multiply-add datapath (mac_res = mul_1*mul_2 + add) between two requesters.
- Port 0 submits trinomial jobs, (a*x+b)*x+c, evaluated as two dependent MAC passes.
- Port 1 submits sum-of-products streams, y += a*x per term, closed by a last flag.
- Sits between the input front-end and the MAC unit, and returns one tagged 25-bit result per job.

Parameters:
- DATA_W, 8: signed operand width of a, b, c, x.
- ACC_W, 25: signed result/accumulator width.
- TIMEOUT, 16: idle cycles allowed between SOP terms before abort.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- t_valid  in  1  trinomial job offered
- t_ready  out  1  trinomial job accepted this cycle
- t_a, t_b, t_c, t_x  in  DATA_W each  signed trinomial operands
- s_valid  in  1  SOP term offered
- s_ready  out  1  SOP term accepted
- s_a, s_x  in  DATA_W each  signed SOP term
- s_last  in  1  final term of SOP job
- mac_op_valid  out  1  one-cycle MAC issue strobe
- mac_mul_1  out  17  signed multiplicand
- mac_mul_2  out  DATA_W  signed multiplier
- mac_add  out  ACC_W  signed addend
- mac_res_valid  in  1  MAC result strobe, in-order, any latency ≥1
- mac_res  in  ACC_W  signed MAC result
- res_valid  out  1  job result available
- res_ready  in  1  consumer accepts result
- res_data  out  ACC_W  signed result
- res_src  out  1  0 = trinomial, 1 = SOP
- res_err  out  1  SOP aborted by timeout; res_data = partial sum

Behaviour:
- Reset, asynchronous and immediate: state IDLE; all outputs 0; accumulator 0; rr_last = 1, so port 0 wins first.
- States: IDLE, T_P1, T_W1, T_P2, T_W2, S_TERM, S_ISSUE, S_WAIT, OUT.
- Arbitration, only in IDLE:
  - If only one valid is high, that port is granted.
  - If both are high, the port not in rr_last is granted.
  - rr_last updates on grant.
  - Ready is combinational: t_ready = IDLE & grant0; s_ready = (IDLE & grant1) | S_TERM.
- Operands are latched on the accept edge and are never re-read from the ports.
- Trinomial path:
  - T_P1: mac_op_valid=1, mul_1 = sext(a), mul_2 = x, add = sext(b). Go to T_W1.
  - T_W1: on mac_res_valid, latch p1 (17-bit signed; a*x+b always fits).
  - T_P2: mul_1 = p1, mul_2 = x, add = sext(c). Go to T_W2.
  - T_W2: on mac_res_valid, go to OUT with res_src=0.
- SOP path:
  - The accepted term goes to S_ISSUE: mul_1 = sext(a), mul_2 = x, add = acc. Then S_WAIT.
  - On mac_res_valid: acc <= mac_res. If the latched last=1, go to OUT with res_src=1; otherwise go to S_TERM.
  - S_TERM: port 1 keeps ownership; port 0 is stalled until the SOP job ends.
  - A timeout counter counts S_TERM cycles with s_valid=0. At TIMEOUT it goes to OUT with res_err=1 and res_data = acc.
  - acc clears to 0 when OUT is left for an SOP job.
- Arithmetic: two's complement with ACC_W wrap. No saturation.
- Only one MAC op is ever outstanding. mac_res_valid outside T_W1/T_W2/S_WAIT is ignored.
- OUT: res_valid=1 and res_data/src/err are held stable until res_ready. On acceptance, return to IDLE; a new grant may occur the next cycle.
- Latency with MAC latency L (MAC result in cycle n+L when issued in cycle n):
  - Trinomial: accept edge 0 → res_valid at cycle 2L+3.
  - SOP: each term costs L+2 cycles from acceptance to the next s_ready.
- Reset mid-job: job discarded, no result emitted; late MAC results are ignored in IDLE.

Decomposition:
- Shared package mac_pkg holds:
  - DATA_W and ACC_W
  - state enum
  - RES_SRC_TRI / RES_SRC_SOP constants
- Sub-module rr_arbiter2 provides the 2-way round-robin grant with the rr_last register.
- The MAC datapath stays external. The bench uses a behavioural MAC with configurable L.

Test Plan:
- Trinomial, L=1: a=-5, x=-3, b=-2, c=-1 → one res_valid with res_data=-40, src=0, err=0, at cycle 5 after accept.
- Trinomial a=9, x=8, b=7, c=6 with res_ready held low 4 cycles → res_data=638 held stable, then IDLE after acceptance.
- SOP terms (2,3), (-4,5), (7,7, last) → res_data=35, src=1. A t_valid pending throughout is not accepted until OUT clears.
- Both valids high in IDLE after reset → port 0 granted first. Then, with both high again, port 1 is granted, then port 0 again (strict alternation).
- SOP term (3,4), then s_valid low for TIMEOUT=16 cycles → res_err=1, res_data=12. The next SOP job starts from acc=0.
- Reset asserted during T_W1, with the MAC result arriving after reset → no res_valid; all outputs 0; the next trinomial job completes correctly.
